// File: rtl/collective_port_arbiter_pkg.sv
// Shared definitions for the MPI collective router output-port arbiters:
// flit flag positions, the arbiter state encoding and credit counter sizing.
package collective_router_pkg;

  // Flag positions are measured down from the top of the flit, so one
  // definition serves every flit width: head = FLIT_WIDTH-1, tail = FLIT_WIDTH-2.
  localparam int HEAD_BIT_OFS = 1;
  localparam int TAIL_BIT_OFS = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // A credit counter has to hold every value from 0 up to the full depth.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/collective_port_arbiter_if.sv
// Bundle between one router output port arbiter and its surroundings: the
// input FIFO heads, the outgoing link and the downstream credit return.
// The master modport is the arbiter's view; slave is the FIFO/link side.
interface collective_port_arbiter_if
  import collective_router_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int FLIT_WIDTH = 64
);

  localparam int IDXW = $clog2(NUM_IN);

  logic [NUM_IN*FLIT_WIDTH-1:0] in_flit;
  logic [NUM_IN-1:0]            in_empty;
  logic [NUM_IN-1:0]            in_consume;
  logic [FLIT_WIDTH-1:0]        out_flit;
  logic                         out_valid;
  logic                         credit_return;
  logic [IDXW-1:0]              grant_id;
  logic                         busy;

  modport master (
    input  in_flit,
    input  in_empty,
    input  credit_return,
    output in_consume,
    output out_flit,
    output out_valid,
    output grant_id,
    output busy
  );

  modport slave (
    output in_flit,
    output in_empty,
    output credit_return,
    input  in_consume,
    input  out_flit,
    input  out_valid,
    input  grant_id,
    input  busy
  );

endinterface

// File: rtl/collective_port_arbiter_rr_priority_select.sv
// Round-robin priority picker: returns the first asserted request found when
// scanning upward from ptr_i with wrap-around. Purely combinational so that
// every output port of the router can reuse it.
module rr_priority_select #(
  parameter  int NUM_IN = 4,
  localparam int IDXW   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDXW-1:0]   ptr_i,
  output logic [NUM_IN-1:0] gnt_o,
  output logic [IDXW-1:0]   idx_o,
  output logic              valid_o
);

  // Walk the requests in priority order starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = (int'(ptr_i) + k) % NUM_IN;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        idx_o    = IDXW'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collective_port_arbiter.sv
// Packet-locked round-robin arbiter for one output port of the MPI collective
// router. Pops the winning input FIFO, registers the flit onto the link and
// keeps the grant until the packet's tail has gone out. Flow control is
// credit-based against the downstream buffer.
// Optional statistics (pkt_count, stall_cycles) are built only when
// COLLECTIVE_ARB_STATS_EN is defined.
// The connected interface instance must use the same NUM_IN/FLIT_WIDTH.
module collective_port_arbiter
  import collective_router_pkg::*;
#(
  parameter int NUM_IN       = 4,
  parameter int FLIT_WIDTH   = 64,
  parameter int CREDIT_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  collective_port_arbiter_if.master  arb_if
`ifdef COLLECTIVE_ARB_STATS_EN
  ,
  output logic [NUM_IN*32-1:0]       pkt_count,
  output logic [31:0]                stall_cycles
`endif
);

  localparam int IDXW     = $clog2(NUM_IN);
  localparam int CW       = credit_width(CREDIT_DEPTH);
  localparam int HEAD_BIT = FLIT_WIDTH - HEAD_BIT_OFS;
  localparam int TAIL_BIT = FLIT_WIDTH - TAIL_BIT_OFS;
  localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_DEPTH);

  arb_state_e            state_q, state_d;
  logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]       grant_q, grant_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
  logic                  out_valid_q, out_valid_d;

  logic [FLIT_WIDTH-1:0] flit_arr [NUM_IN];
  logic [NUM_IN-1:0]     eligible;
  logic [NUM_IN-1:0]     rr_gnt;
  logic [IDXW-1:0]       rr_idx;
  logic                  rr_valid;
  logic [IDXW-1:0]       sel;
  logic                  sel_ready;
  logic                  has_credit;
  logic                  send;
  logic                  sel_tail;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic [NUM_IN-1:0]     consume;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + IDXW'(1);
  endfunction

  // Split the flat flit bus per input; only a non-empty FIFO showing a head may start a packet.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      flit_arr[i] = arb_if.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
      eligible[i] = ~arb_if.in_empty[i] & flit_arr[i][HEAD_BIT];
    end
  end

  rr_priority_select #(
    .NUM_IN (NUM_IN)
  ) u_rr_select (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  assign has_credit = (credits_q != '0);

  // Pick the source, decide whether it may pop this cycle and work out the next lock state.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    sel         = grant_q;
    sel_ready   = 1'b0;
    consume     = '0;
    send        = 1'b0;
    sel_flit    = '0;
    sel_tail    = 1'b0;
    out_valid_d = 1'b0;
    out_flit_d  = out_flit_q;

    if (state_q == ARB_IDLE) begin
      sel       = rr_idx;
      sel_ready = rr_valid;
    end else begin
      sel       = grant_q;
      sel_ready = ~arb_if.in_empty[grant_q];
    end

    send     = sel_ready && has_credit && !rst;
    sel_flit = flit_arr[sel];
    sel_tail = sel_flit[TAIL_BIT];

    if (send) begin
      consume     = (state_q == ARB_IDLE) ? rr_gnt : (NUM_IN'(1) << grant_q);
      out_valid_d = 1'b1;
      out_flit_d  = sel_flit;
      if (sel_tail) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = next_idx(sel);
      end else begin
        state_d = ARB_LOCKED;
        grant_d = sel;
      end
    end
  end

  // Spend a credit per flit sent, regain one per return; a return while full is dropped.
  always_comb begin
    credits_d = credits_q;
    if (send && !arb_if.credit_return) begin
      credits_d = credits_q - CW'(1);
    end else if (!send && arb_if.credit_return && (credits_q != CREDIT_FULL)) begin
      credits_d = credits_q + CW'(1);
    end
  end

  // Arbiter state, round-robin pointer, credits and the registered link stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      credits_q   <= CREDIT_FULL;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      credits_q   <= credits_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign arb_if.in_consume = consume;
  assign arb_if.out_flit   = out_flit_q;
  assign arb_if.out_valid  = out_valid_q;
  assign arb_if.grant_id   = grant_q;
  assign arb_if.busy       = (state_q == ARB_LOCKED);

`ifdef COLLECTIVE_ARB_STATS_EN
  logic [31:0] pkt_q [NUM_IN];
  logic [31:0] stall_q;
  logic        pending;

  // Something is waiting on this port: an eligible head while idle, or the owner's next flit.
  always_comb begin
    pending = (state_q == ARB_IDLE) ? (|eligible) : ~arb_if.in_empty[grant_q];
  end

  // Count completed packets per input (wrapping) and credit-starved cycles (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        pkt_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      if (send && sel_tail) begin
        pkt_q[sel] <= pkt_q[sel] + 32'd1;
      end
      if (pending && !has_credit && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_pkt_count
    assign pkt_count[g*32 +: 32] = pkt_q[g];
  end
  assign stall_cycles = stall_q;
`endif

`ifndef SYNTHESIS
  // Pop strobes must stay one-hot, never hit an empty FIFO, never run without
  // credit, and never start a packet from a headless flit; the downstream
  // must not hand back more credits than it has slots.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(consume))
        else $error("collective_port_arbiter: in_consume not one-hot");
      assert ((consume & arb_if.in_empty) == '0)
        else $error("collective_port_arbiter: pop of an empty FIFO");
      assert ((consume == '0) || has_credit)
        else $error("collective_port_arbiter: pop without credit");
      assert (!((state_q == ARB_IDLE) && ((consume & ~eligible) != '0)))
        else $error("collective_port_arbiter: framing error, non-head flit popped while idle");
      assert (!(arb_if.credit_return && (credits_q == CREDIT_FULL)))
        else $error("collective_port_arbiter: credit returned with counter already full");
    end
  end
`endif

endmodule

// File: tb/tb_collective_port_arbiter.sv
// Randomized self-checking bench for collective_port_arbiter. Input FIFOs are
// modelled as queues fed by a packet generator; a behavioural reference
// (owner / pointer / credit integers) predicts every pop and link flit.
module tb_collective_port_arbiter;
  import collective_router_pkg::*;

  localparam int NUM_IN       = 4;
  localparam int FLIT_WIDTH   = 16;
  localparam int CREDIT_DEPTH = 8;
  localparam int IDXW         = $clog2(NUM_IN);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  collective_port_arbiter_if #(.NUM_IN(NUM_IN), .FLIT_WIDTH(FLIT_WIDTH)) arbIf ();

`ifdef COLLECTIVE_ARB_STATS_EN
  logic [NUM_IN*32-1:0] pktCount;
  logic [31:0]          stallCycles;
`endif

  collective_port_arbiter #(
    .NUM_IN       (NUM_IN),
    .FLIT_WIDTH   (FLIT_WIDTH),
    .CREDIT_DEPTH (CREDIT_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arb_if       (arbIf)
`ifdef COLLECTIVE_ARB_STATS_EN
    ,
    .pkt_count    (pktCount),
    .stall_cycles (stallCycles)
`endif
  );

  logic [FLIT_WIDTH-1:0] fifo [NUM_IN][$];
  int genRem [NUM_IN];
  bit genEnable;
  int retPct;

  int mOwner;
  int mPtr;
  int mCredits;
  bit expValid;
  logic [FLIT_WIDTH-1:0] expFlit;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [FLIT_WIDTH-1:0] makeFlit(input bit h, input bit t, input int src);
    logic [FLIT_WIDTH-3:0] payload;
    payload = FLIT_WIDTH-2'($urandom);
    payload[FLIT_WIDTH-3 -: 2] = 2'(src);
    return {h, t, payload};
  endfunction

  // Trickle flits into the FIFOs so that packets can run dry mid-way.
  task automatic refill();
    bit h;
    bit t;
    for (int i = 0; i < NUM_IN; i++) begin
      if (genEnable && fifo[i].size() < 6 && $urandom_range(0, 3) != 0) begin
        h = 1'b0;
        if (genRem[i] == 0) begin
          genRem[i] = $urandom_range(1, 4);
          h = 1'b1;
        end
        t = (genRem[i] == 1);
        fifo[i].push_back(makeFlit(h, t, i));
        genRem[i]--;
      end
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_IN; i++) begin
      arbIf.in_empty[i] = (fifo[i].size() == 0);
      if (fifo[i].size() == 0)
        arbIf.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH] = FLIT_WIDTH'($urandom);
      else
        arbIf.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH] = fifo[i][0];
    end
    arbIf.credit_return = (mCredits < CREDIT_DEPTH) && ($urandom_range(0, 99) < retPct);
  endtask

  // Reference decision: owner keeps the port; otherwise first head from mPtr onward.
  task automatic modelDecide(output int sel, output bit send);
    logic [FLIT_WIDTH-1:0] f;
    int j;
    sel = -1;
    if (mOwner >= 0) begin
      if (fifo[mOwner].size() > 0) sel = mOwner;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        j = (mPtr + k) % NUM_IN;
        if (sel < 0 && fifo[j].size() > 0) begin
          f = fifo[j][0];
          if (f[FLIT_WIDTH-1]) sel = j;
        end
      end
    end
    send = (sel >= 0) && (mCredits > 0);
  endtask

  task automatic stepCycle();
    int sel;
    bit send;
    bit ret;
    logic [NUM_IN-1:0] expConsume;
    logic [FLIT_WIDTH-1:0] f;
    refill();
    applyStimulus();
    #1;
    modelDecide(sel, send);
    expConsume = send ? (NUM_IN'(1) << sel) : '0;
    checkOutput("in_consume", arbIf.in_consume, expConsume);
    ret = arbIf.credit_return;
    expValid = send;
    if (send) begin
      f = fifo[sel].pop_front();
      expFlit = f;
      if (f[FLIT_WIDTH-2]) begin
        mOwner = -1;
        mPtr   = (sel + 1) % NUM_IN;
      end else begin
        mOwner = sel;
      end
    end
    if (send && !ret) mCredits--;
    else if (!send && ret) mCredits++;
    @(posedge clk);
    #1;
    checkOutput("out_valid", arbIf.out_valid, expValid);
    if (expValid) checkOutput("out_flit", arbIf.out_flit, expFlit);
    checkOutput("busy", arbIf.busy, mOwner >= 0);
    if (mOwner >= 0) checkOutput("grant_id", arbIf.grant_id, mOwner);
  endtask

  // One reset cycle with the FIFOs as they are; afterwards FIFOs and model restart clean.
  task automatic resetMidRun();
    applyStimulus();
    arbIf.credit_return = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_consume", arbIf.in_consume, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      fifo[i].delete();
      genRem[i] = 0;
    end
    mOwner = -1; mPtr = 0; mCredits = CREDIT_DEPTH; expValid = 1'b0;
    checkOutput("rst_out_valid", arbIf.out_valid, 0);
    checkOutput("rst_busy", arbIf.busy, 0);
    checkOutput("rst_grant_id", arbIf.grant_id, 0);
    checkOutput("rst_out_flit", arbIf.out_flit, 0);
  endtask

  initial begin
    bit lockSeen;
    genEnable = 1'b0;
    retPct    = 0;
    mOwner = -1; mPtr = 0; mCredits = CREDIT_DEPTH; expValid = 1'b0; expFlit = '0;
    for (int i = 0; i < NUM_IN; i++) genRem[i] = 0;
    rst = 1'b1;
    applyStimulus();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_consume", arbIf.in_consume, '0);
    rst = 1'b0;
    checkOutput("reset_out_valid", arbIf.out_valid, 0);
    checkOutput("reset_out_flit", arbIf.out_flit, 0);
    checkOutput("reset_busy", arbIf.busy, 0);
    checkOutput("reset_grant_id", arbIf.grant_id, 0);

    $display("[TB] random traffic with alternating credit return rates");
    genEnable = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      retPct = ((c / 250) % 2 == 0) ? 60 : 10;
      stepCycle();
    end

    $display("[TB] reset while a packet holds the port");
    retPct = 50;
    lockSeen = 1'b0;
    for (int c = 0; c < 300 && !lockSeen; c++) begin
      stepCycle();
      if (mOwner >= 0 && fifo[mOwner].size() > 0) lockSeen = 1'b1;
    end
    checkOutput("lock_seen", lockSeen, 1);
    resetMidRun();

    $display("[TB] headless flit on idle input, credit refill after reset");
    genEnable = 1'b0;
    retPct    = 0;
    fifo[0].push_back(makeFlit(1'b0, 1'b0, 0));
    for (int n = 0; n < CREDIT_DEPTH + 1; n++) fifo[3].push_back(makeFlit(1'b1, 1'b1, 3));
    repeat (CREDIT_DEPTH + 4) stepCycle();
    checkOutput("starved_backlog", fifo[3].size(), 1);
    checkOutput("headless_kept", fifo[0].size(), 1);
    retPct = 100;
    repeat (4) stepCycle();
    checkOutput("drained_backlog", fifo[3].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
